aes_round_key_gen: RTL and testbench
====================================

# aes_round_key_gen

AES-128 key-schedule engine that produces the round keys consumed by the add-round-key / inv-add-round-key XOR stages. Accepts one 128-bit cipher key via a valid/ready handshake, expands it into all 11 round keys in a local store, one round per cycle. It then streams the keys out over a valid/ready interface, in encryption order (0..10) or decryption order (10..0).

## Interface
Parameters:
- NR, 10, number of expansion rounds (AES-128); store depth is NR+1.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- key_in  input  128  cipher key; byte 0 = key_in[127:120]
- key_valid  input  1  key_in valid
- key_ready  output  1  high only in IDLE; handshake = key_valid && key_ready
- rk_data  output  128  round key, same byte order as key_in
- rk_round  output  4  round index of rk_data (0..10)
- rk_valid  output  1  rk_data/rk_round valid
- rk_ready  input  1  consumer accepts; beat = rk_valid && rk_ready
- rk_last  output  1  high with final beat of a key set
- busy  output  1  high in EXPAND or STREAM

## Operation
- States: IDLE, EXPAND, STREAM.
- IDLE: key_ready=1. On handshake: store[0] <= key_in, round counter rc <= 1, go EXPAND.
- EXPAND: each cycle compute store[rc] from store[rc-1]:
  - w3' = SubWord(RotWord(w3)) ^ {Rcon[rc],24'h0}; w0n = w0^w3'; w1n = w1^w0n; w2n = w2^w1n; w3n = w3^w2n.
  - RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}. SubWord: 4 parallel forward S-box lookups (local 256-entry function).
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - After rc=10 is written, go STREAM with output pointer at first key of the configured order.
- STREAM: rk_valid=1, rk_data=store[ptr], rk_round=ptr. On beat, advance ptr. rk_last=1 when ptr is the final index. Beat with rk_last -> IDLE.
- Backpressure: while rk_valid && !rk_ready, rk_data/rk_round/rk_last hold stable.
- key_valid outside IDLE is ignored (key_ready=0); no key is queued.
- All XOR/byte ops are exact 8-bit, no carries; Rcon applies to the most significant byte of the word only.

## Timing
- Reset values: key_ready=0 during the rst cycle, 1 in the first cycle after; rk_valid=0, rk_last=0, busy=0, rk_round=0, rk_data=0; state=IDLE.
- Key handshake at cycle T -> EXPAND cycles T+1..T+10 (store[1..10]) -> rk_valid first high at T+11.
- With rk_ready tied high: 11 beats at T+11..T+21, rk_last at T+21, key_ready high at T+22.
- Minimum key-to-key period: 22 cycles.
- rst asserted in any state: the next cycle is IDLE with all outputs at reset values. A partial expansion is discarded and never streamed. Store contents are don't-care.
- rst and key_valid in the same cycle: rst wins; the key is not captured.

## Configuration
- AES_KEY_DEC_ORDER_EN defined: STREAM emits rounds 10,9,...,0. rk_last is asserted with round 0. This is the order the inverse cipher consumes.
- Not defined: STREAM emits rounds 0,1,...,10. rk_last is asserted with round 10.
- Expansion behaviour and latency are identical in both builds.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; first beat at T+11. Round 0 first (macro off) or round 10 first (macro on).
- Same key, rk_ready toggled pseudo-randomly -> each held beat keeps rk_data/rk_round stable; exactly 11 beats; rk_last exactly once.
- key_valid held high with a second key (all-zero) during EXPAND/STREAM -> ignored. After return to IDLE it is accepted: round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- rst pulsed at T+5 mid-EXPAND -> rk_valid never rises. Next cycle: key_ready=1, busy=0. A fresh key then streams correct keys.
- rst asserted during STREAM after 4 beats -> rk_valid=0 the next cycle; no further beats.
- rst and key_valid asserted in the same cycle -> key not captured; busy stays 0.

Source files
------------

// File: rtl/aes_round_key_gen_if.sv
// Key-load and round-key stream bundle for aes_round_key_gen.
// slave = key-schedule engine side; master = key source / round-key consumer side.
interface aes_round_key_gen_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;

    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk_data, rk_round, rk_valid, rk_last, busy
    );

    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk_data, rk_round, rk_valid, rk_last, busy
    );
endinterface

// File: rtl/aes_round_key_gen.sv
// AES-128 key schedule: expands one cipher key into NR+1 round keys, then streams them out.
// Latency: key handshake at T -> first round key valid at T+11 (one expansion round per cycle).
// Backpressure: rk_* hold while rk_valid && !rk_ready; key_ready only in IDLE. AES_KEY_DEC_ORDER_EN streams 10..0.
module aes_round_key_gen #(
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              rst,
    aes_round_key_gen_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

`ifdef AES_KEY_DEC_ORDER_EN
    localparam logic [3:0] FIRST_PTR = 4'(NR);
    localparam logic [3:0] LAST_PTR  = 4'd0;
`else
    localparam logic [3:0] FIRST_PTR = 4'd0;
    localparam logic [3:0] LAST_PTR  = 4'(NR);
`endif

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_TBL[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] expand_step(input logic [127:0] k, input logic [7:0] rc_byte);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc_byte, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [1:0]   state;
    logic [3:0]   rc;
    logic [3:0]   ptr;
    logic [127:0] store [0:NR];
    logic [127:0] prev_rk;
    logic [127:0] next_rk;
    logic         key_fire;
    logic         beat;

    // Gating with rst keeps key_ready low in the reset cycle and lets rst win over key_valid.
    assign bus.key_ready = (state == IDLE) && !rst;
    assign key_fire      = bus.key_valid && bus.key_ready;

    assign bus.rk_valid  = (state == STREAM);
    assign bus.rk_data   = bus.rk_valid ? store[ptr] : '0;
    assign bus.rk_round  = bus.rk_valid ? ptr : 4'd0;
    assign bus.rk_last   = bus.rk_valid && (ptr == LAST_PTR);
    assign bus.busy      = (state != IDLE);
    assign beat          = bus.rk_valid && bus.rk_ready;

    // rc stays within 1..NR so the read index is always a written entry.
    assign prev_rk = store[rc - 4'd1];
    assign next_rk = expand_step(prev_rk, rcon(rc));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rc    <= 4'd1;
            ptr   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_fire) begin
                        state <= EXPAND;
                        rc    <= 4'd1;
                    end
                end
                EXPAND: begin
                    if (rc == 4'(NR)) begin
                        state <= STREAM;
                        ptr   <= FIRST_PTR;
                    end else begin
                        rc <= rc + 4'd1;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        if (bus.rk_last) begin
                            state <= IDLE;
                        end else begin
`ifdef AES_KEY_DEC_ORDER_EN
                            ptr <= ptr - 4'd1;
`else
                            ptr <= ptr + 4'd1;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Key store needs no reset: it is only read after a full expansion.
    always_ff @(posedge clk) begin
        if (key_fire) begin
            store[0] <= bus.key_in;
        end else if (state == EXPAND) begin
            store[rc] <= next_rk;
        end
    end
endmodule

// File: tb/tb_aes_round_key_gen.sv
// Bench for aes_round_key_gen: vector table plus reset/hold corner sequences, GF(2^8) reference model.
// Expected beats are queued at key acceptance and popped on each rk handshake.
module tb_aes_round_key_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_key_gen_if bus ();
    aes_round_key_gen #(.NR(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0]   round;
        logic [127:0] data;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        int           mode;
        logic [127:0] r1;
        logic [127:0] r10;
    } vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    exp_t         q[$];
    vec_t         vecs[4];
    logic [7:0]   sb[256];
    logic [127:0] model_rk[0:10];
    logic [127:0] cap[0:10];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_acc = -1000;
    int acc_gap = 0;
    int n_acc = 0;
    int set_beats = 0;
    int total_beats = 0;
    int ready_mode = 0;
    bit seen_valid = 1'b0;
    bit set_done = 1'b0;
    bit hold = 1'b0;
    bit idle_chk = 1'b0;
    logic [127:0] h_data;
    logic [3:0]   h_round;
    logic         h_last;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rcb;
        rcb = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcb, 24'h000000};
                rcb = gm(rcb, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.rk_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: sampled mid-cycle, ahead of the edge that registers the handshakes.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold = 1'b0;
            idle_chk = 1'b0;
            seen_valid = 1'b0;
            t_acc = -1000;
        end else begin
            if (hold) begin
                chk("hold_valid", bus.rk_valid, 1'b1);
                chk("hold_data", bus.rk_data, h_data);
                chk("hold_round", bus.rk_round, h_round);
                chk("hold_last", bus.rk_last, h_last);
            end
            hold = 1'b0;
            if (idle_chk) begin
                chk("idle_key_ready", bus.key_ready, 1'b1);
                chk("idle_busy", bus.busy, 1'b0);
                idle_chk = 1'b0;
            end
            if (bus.rk_valid && !seen_valid) begin
                seen_valid = 1'b1;
                chk("first_valid_cycle", 128'(cyc), 128'(t_acc + 11));
            end
            if (bus.rk_valid && bus.rk_ready) begin
                set_beats++;
                total_beats++;
                cap[bus.rk_round] = bus.rk_data;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got round %0d, expected no beat (cycle %0d)", bus.rk_round, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("beat_data", bus.rk_data, e.data);
                    chk("beat_round", bus.rk_round, e.round);
                    chk("beat_last", bus.rk_last, e.last);
                end
                if (bus.rk_last) begin
                    chk("beats_per_set", set_beats, 11);
                    set_done = 1'b1;
                    idle_chk = 1'b1;
                end
            end else if (bus.rk_valid) begin
                hold = 1'b1;
                h_data = bus.rk_data;
                h_round = bus.rk_round;
                h_last = bus.rk_last;
            end
            if (bus.key_valid && bus.key_ready) begin
                acc_gap = cyc - t_acc;
                t_acc = cyc;
                n_acc++;
                seen_valid = 1'b0;
                set_done = 1'b0;
                set_beats = 0;
                model_expand(bus.key_in);
                for (int j = 0; j <= 10; j++) begin
                    exp_t e;
`ifdef AES_KEY_DEC_ORDER_EN
                    e.round = 4'(10 - j);
`else
                    e.round = 4'(j);
`endif
                    e.data = model_rk[e.round];
                    e.last = (j == 10);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lim, input string nm);
        int k = 0;
        while (!set_done && k < lim) begin
            tick();
            k++;
        end
        chk(nm, set_done, 1'b1);
    endtask

    task automatic send_key(input logic [127:0] k);
        bus.key_in = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        int nb;
        int k;
        vecs[0] = '{FIPS_KEY, 0, FIPS_R1, FIPS_R10};
        vecs[1] = '{FIPS_KEY, 1, FIPS_R1, FIPS_R10};
        vecs[2] = '{128'h0,   0, ZERO_R1, ZERO_R10};
        vecs[3] = '{128'h0,   1, ZERO_R1, ZERO_R10};
        build_sbox();

        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_in = '0;
        bus.rk_ready = 1'b1;
        tick();
        chk("rst_key_ready", bus.key_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rk_valid", bus.rk_valid, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_key_ready", bus.key_ready, 1'b1);
        chk("post_rst_rk_valid", bus.rk_valid, 1'b0);
        chk("post_rst_rk_last", bus.rk_last, 1'b0);
        chk("post_rst_rk_round", bus.rk_round, 4'd0);
        chk("post_rst_rk_data", bus.rk_data, 128'h0);
        chk("post_rst_busy", bus.busy, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ready_mode = vecs[i].mode;
            for (int r = 0; r <= 10; r++) cap[r] = '0;
            send_key(vecs[i].key);
            wait_done(400, "vec_done");
            chk("vec_round1", cap[1], vecs[i].r1);
            chk("vec_round10", cap[10], vecs[i].r10);
            chk("vec_queue_empty", q.size(), 0);
        end
        ready_mode = 0;
        tick();

        // key_valid held through a whole set: second key only taken once IDLE returns.
        n0 = n_acc;
        bus.key_in = FIPS_KEY;
        bus.key_valid = 1'b1;
        tick();
        bus.key_in = '0;
        k = 0;
        while (n_acc < n0 + 2 && k < 100) begin
            tick();
            k++;
        end
        bus.key_valid = 1'b0;
        chk("held_key_accepts", n_acc, n0 + 2);
        chk("held_key_gap", acc_gap, 22);
        wait_done(100, "held_key_done");
        chk("held_key_round10", cap[10], ZERO_R10);

        // Reset mid-expansion at T+5.
        tick();
        nb = total_beats;
        send_key(FIPS_KEY);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_exp_key_ready", bus.key_ready, 1'b1);
        chk("rst_exp_busy", bus.busy, 1'b0);
        chk("rst_exp_rk_valid", bus.rk_valid, 1'b0);
        chk("rst_exp_rk_data", bus.rk_data, 128'h0);
        repeat (20) tick();
        chk("rst_exp_no_beats", total_beats, nb);
        send_key(128'h0);
        wait_done(100, "after_rst_done");
        chk("after_rst_round10", cap[10], ZERO_R10);

        // Reset in STREAM after four beats.
        tick();
        send_key(FIPS_KEY);
        k = 0;
        while (set_beats < 4 && k < 100) begin
            tick();
            k++;
        end
        chk("stream_four_beats", set_beats, 4);
        nb = total_beats;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_stream_rk_valid", bus.rk_valid, 1'b0);
        chk("rst_stream_busy", bus.busy, 1'b0);
        repeat (20) tick();
        chk("rst_stream_no_beats", total_beats, nb);

        // rst and key_valid in the same cycle.
        n0 = n_acc;
        rst = 1'b1;
        bus.key_in = FIPS_KEY;
        bus.key_valid = 1'b1;
        #1;
        chk("rst_key_same_ready", bus.key_ready, 1'b0);
        tick();
        rst = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        chk("rst_key_same_busy", bus.busy, 1'b0);
        chk("rst_key_same_idle", bus.key_ready, 1'b1);
        repeat (5) tick();
        chk("rst_key_same_busy_later", bus.busy, 1'b0);
        chk("rst_key_same_no_accept", n_acc, n0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
